// File: rtl/tlb_maint_sequencer.sv
// Serialises TLB maintenance operations onto the MMU maintenance port: drain in-flight
// translations, issue for one cycle, present the held result, then request a refetch.
module tlb_maint_sequencer #(
    parameter int          TLB_n     = 5,
    parameter logic [3:0]  MMU_TYPE  = 4'd11,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [4:0]       req_subtype,
    input  logic [4:0]       req_op,
    input  logic [31:0]      req_rj,
    input  logic [31:0]      req_rk,
    input  logic [31:0]      req_tlbidx,
    input  logic             flush,
    input  logic             inflight0,
    input  logic             inflight1,
    output logic             hold_xlat,
    output logic [3:0]       seq_MMU_type,
    output logic [4:0]       seq_MMU_subtype,
    output logic [15:0]      seq_MMU_excp_arg,
    output logic [31:0]      seq_MMU_rj,
    output logic [31:0]      seq_MMU_rk,
    output logic [31:0]      seq_MMU_TLBIDX,
    output logic             seq_MMU_stallw,
    output logic             resp_valid,
    output logic             resp_err,
    output logic [TLB_n-1:0] resp_index,
    output logic             refetch_req
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_ISSUE,
        S_RESP,
        S_REFETCH
    } state_t;

    state_t state_q, state_d;
    logic [15:0] lfsr_q, lfsr_d;
    logic [4:0]  sub_q, sub_d, op_q, op_d;
    logic [31:0] rj_q, rj_d, rk_q, rk_d, idx_q, idx_d;
    logic [3:0]  type_q, type_d;
    logic [4:0]  msub_q, msub_d;
    logic [15:0] excp_q, excp_d;
    logic [31:0] mrj_q, mrj_d, mrk_q, mrk_d, midx_q, midx_d;
    logic        stallw_q, stallw_d;
    logic        resp_valid_q, resp_valid_d, resp_err_q, resp_err_d;
    logic [TLB_n-1:0] resp_index_q, resp_index_d;
    logic        refetch_q, refetch_d;

    logic        legal, changes_tlb;
    logic [31:0] issue_idx;

    assign legal       = (sub_q >= 5'd1) && (sub_q <= 5'd5);
    assign changes_tlb = (sub_q >= 5'd3) && (sub_q <= 5'd5);
    // TLBFILL replaces only the index field with the pseudo-random victim.
    assign issue_idx   = (sub_q == 5'd4) ? {idx_q[31:TLB_n], lfsr_q[TLB_n-1:0]} : idx_q;

    always_comb begin
        state_d      = state_q;
        lfsr_d       = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
        sub_d        = sub_q;
        op_d         = op_q;
        rj_d         = rj_q;
        rk_d         = rk_q;
        idx_d        = idx_q;
        type_d       = 4'd0;
        msub_d       = 5'd0;
        excp_d       = 16'd0;
        mrj_d        = 32'd0;
        mrk_d        = 32'd0;
        midx_d       = 32'd0;
        stallw_d     = 1'b1;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_index_d = resp_index_q;
        refetch_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    sub_d   = req_subtype;
                    op_d    = req_op;
                    rj_d    = req_rj;
                    rk_d    = req_rk;
                    idx_d   = req_tlbidx;
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else if (!legal) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    resp_index_d = idx_q[TLB_n-1:0];
                end else if (!inflight0 && !inflight1) begin
                    state_d      = S_ISSUE;
                    type_d       = MMU_TYPE;
                    msub_d       = sub_q;
                    excp_d       = {11'b0, op_q};
                    mrj_d        = rj_q;
                    mrk_d        = rk_q;
                    midx_d       = issue_idx;
                    stallw_d     = 1'b0;
                    resp_index_d = issue_idx[TLB_n-1:0];
                end
            end
            S_ISSUE: begin
                state_d      = S_RESP;
                resp_valid_d = 1'b1;
            end
            S_RESP: begin
                if (changes_tlb) begin
                    state_d   = S_REFETCH;
                    refetch_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REFETCH: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            lfsr_q       <= LFSR_SEED;
            sub_q        <= 5'd0;
            op_q         <= 5'd0;
            rj_q         <= 32'd0;
            rk_q         <= 32'd0;
            idx_q        <= 32'd0;
            type_q       <= 4'd0;
            msub_q       <= 5'd0;
            excp_q       <= 16'd0;
            mrj_q        <= 32'd0;
            mrk_q        <= 32'd0;
            midx_q       <= 32'd0;
            stallw_q     <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_index_q <= '0;
            refetch_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            lfsr_q       <= lfsr_d;
            sub_q        <= sub_d;
            op_q         <= op_d;
            rj_q         <= rj_d;
            rk_q         <= rk_d;
            idx_q        <= idx_d;
            type_q       <= type_d;
            msub_q       <= msub_d;
            excp_q       <= excp_d;
            mrj_q        <= mrj_d;
            mrk_q        <= mrk_d;
            midx_q       <= midx_d;
            stallw_q     <= stallw_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_index_q <= resp_index_d;
            refetch_q    <= refetch_d;
        end
    end

    assign req_ready        = (state_q == S_IDLE);
    assign hold_xlat        = (state_q != S_IDLE);
    assign seq_MMU_type     = type_q;
    assign seq_MMU_subtype  = msub_q;
    assign seq_MMU_excp_arg = excp_q;
    assign seq_MMU_rj       = mrj_q;
    assign seq_MMU_rk       = mrk_q;
    assign seq_MMU_TLBIDX   = midx_q;
    assign seq_MMU_stallw   = stallw_q;
    assign resp_valid       = resp_valid_q;
    assign resp_err         = resp_err_q;
    assign resp_index       = resp_index_q;
    assign refetch_req      = refetch_q;

endmodule

// File: tb/tb_tlb_maint_sequencer.sv
// Randomised bench for tlb_maint_sequencer: a driver pushes expected issue/response/refetch
// events into queues and a negedge monitor pops and compares them as the DUT presents them.
module tb_tlb_maint_sequencer;

  localparam int IW = 138;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_subtype = '0;
  logic [4:0]  req_op = '0;
  logic [31:0] req_rj = '0;
  logic [31:0] req_rk = '0;
  logic [31:0] req_tlbidx = '0;
  logic        flush = 1'b0;
  logic        inflight0 = 1'b0;
  logic        inflight1 = 1'b0;
  logic        hold_xlat;
  logic [3:0]  seq_MMU_type;
  logic [4:0]  seq_MMU_subtype;
  logic [15:0] seq_MMU_excp_arg;
  logic [31:0] seq_MMU_rj;
  logic [31:0] seq_MMU_rk;
  logic [31:0] seq_MMU_TLBIDX;
  logic        seq_MMU_stallw;
  logic        resp_valid;
  logic        resp_err;
  logic [4:0]  resp_index;
  logic        refetch_req;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // scoreboard queues: {cycle, payload}
  logic [IW-1:0] issue_q[$];
  logic [21:0]   resp_q[$];
  logic [15:0]   refetch_q[$];

  tlb_maint_sequencer dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_subtype(req_subtype), .req_op(req_op),
    .req_rj(req_rj), .req_rk(req_rk), .req_tlbidx(req_tlbidx),
    .flush(flush), .inflight0(inflight0), .inflight1(inflight1),
    .hold_xlat(hold_xlat),
    .seq_MMU_type(seq_MMU_type), .seq_MMU_subtype(seq_MMU_subtype),
    .seq_MMU_excp_arg(seq_MMU_excp_arg), .seq_MMU_rj(seq_MMU_rj),
    .seq_MMU_rk(seq_MMU_rk), .seq_MMU_TLBIDX(seq_MMU_TLBIDX),
    .seq_MMU_stallw(seq_MMU_stallw),
    .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_index(resp_index), .refetch_req(refetch_req)
  );

  // clock / reset-relative cycle count
  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  // reference model: value of the x^16+x^14+x^13+x^11+1 LFSR k steps after reset
  function automatic logic [15:0] lfsr_at(input int k);
    logic [15:0] v;
    v = 16'hACE1;
    for (int i = 0; i < k; i++) v = {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    return v;
  endfunction

  task automatic chk(input string name, input logic [IW-1:0] act, input logic [IW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name,
        {hold_xlat, seq_MMU_type, seq_MMU_subtype, seq_MMU_excp_arg, seq_MMU_rj, seq_MMU_rk,
         seq_MMU_TLBIDX, seq_MMU_stallw, resp_valid, resp_err, resp_index, refetch_req},
        {1'b0, 4'd0, 5'd0, 16'd0, 32'd0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0});
  endtask

  // monitor
  always @(negedge clk) begin
    if (rstn) begin
      if (resp_valid) begin
        if (resp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL resp_unexpected: got resp at cycle %0d expected none", cyc);
        end else begin
          chk("resp", {cyc[15:0], resp_err, resp_index}, resp_q.pop_front());
        end
      end
      if (!seq_MMU_stallw || seq_MMU_type != 4'd0) begin
        if (issue_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL issue_unexpected: got issue at cycle %0d expected none", cyc);
        end else begin
          chk("issue", {cyc[15:0], seq_MMU_stallw, seq_MMU_type, seq_MMU_subtype, seq_MMU_excp_arg,
                        seq_MMU_rj, seq_MMU_rk, seq_MMU_TLBIDX}, issue_q.pop_front());
        end
      end
      if (refetch_req) begin
        if (refetch_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL refetch_unexpected: got refetch at cycle %0d expected none", cyc);
        end else begin
          chk("refetch", cyc[15:0], refetch_q.pop_front());
        end
      end
    end
  end

  task automatic wait_idle();
    int k;
    for (k = 0; k < 20 && !req_ready; k++) @(negedge clk);
    if (!req_ready) begin
      n_tests++; n_fail++;
      $display("FAIL idle_timeout: got req_ready=0 expected 1");
    end
  endtask

  // flush_code: -1 none, >=0 flush in that DRAIN cycle, -2 flush in ISSUE, -3 flush in RESP/REFETCH
  task automatic do_txn(input logic [4:0] sub, input logic [4:0] op, input logic [31:0] rj,
                        input logic [31:0] rk, input logic [31:0] tlbidx, input int d,
                        input int port, input int flush_code);
    int c0;
    bit legal, flushed;
    logic [15:0] lf;
    logic [31:0] eidx;
    @(negedge clk);
    chk("ready_idle", req_ready, 1'b1);
    req_valid = 1'b1; req_subtype = sub; req_op = op;
    req_rj = rj; req_rk = rk; req_tlbidx = tlbidx;
    inflight0 = (port == 0) && (d > 0);
    inflight1 = (port == 1) && (d > 0);
    @(negedge clk);
    req_valid = 1'b0;
    c0 = cyc;
    chk("drain_hold", {hold_xlat, req_ready}, 2'b10);
    legal   = (sub >= 1) && (sub <= 5);
    flushed = legal && (flush_code >= 0) && (flush_code <= d);
    if (!legal) begin
      resp_q.push_back({16'(c0 + 1), 1'b1, tlbidx[4:0]});
    end else if (!flushed) begin
      lf   = lfsr_at(c0 + d);
      eidx = (sub == 5'd4) ? {tlbidx[31:5], lf[4:0]} : tlbidx;
      issue_q.push_back({16'(c0 + d + 1), 1'b0, 4'd11, sub, {11'b0, op}, rj, rk, eidx});
      resp_q.push_back({16'(c0 + d + 2), 1'b0, eidx[4:0]});
      if (sub >= 3) refetch_q.push_back(16'(c0 + d + 3));
    end
    for (int j = 0; ; j++) begin
      inflight0 = (port == 0) && (j < d);
      inflight1 = (port == 1) && (j < d);
      flush = flushed && (j == flush_code);
      if (flush || j >= d || !legal) break;
      @(negedge clk);
    end
    if (flushed) begin
      @(negedge clk);
      flush = 1'b0;
      chk("flush_idle", {req_ready, seq_MMU_stallw, resp_valid}, 3'b110);
    end else if (legal) begin
      for (int k = 1; k <= 3; k++) begin
        @(negedge clk);
        flush = (flush_code == -2 && k == 1) || (flush_code == -3 && k >= 2);
      end
      @(negedge clk);
      flush = 1'b0;
    end
    inflight0 = 1'b0; inflight1 = 1'b0;
    wait_idle();
  endtask

  task automatic reset_in_resp();
    int c0;
    logic [31:0] idx;
    idx = $urandom;
    @(negedge clk);
    req_valid = 1'b1; req_subtype = 5'd3; req_op = 5'd0;
    req_rj = 32'd0; req_rk = 32'd0; req_tlbidx = idx;
    @(negedge clk);
    req_valid = 1'b0;
    c0 = cyc;
    issue_q.push_back({16'(c0 + 1), 1'b0, 4'd11, 5'd3, 16'd0, 32'd0, 32'd0, idx});
    resp_q.push_back({16'(c0 + 2), 1'b0, idx[4:0]});
    @(negedge clk);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1 chk_reset_outputs("reset_mid_resp");
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int sub, d, port, fc, r;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset_state");
    rstn = 1'b1;

    do_txn(5'd1, 5'd0, 32'h1111, 32'h2222, 32'h0000_0007, 0, 0, -1);
    do_txn(5'd3, 5'd0, 32'h0, 32'h0, 32'h0000_0012, 5, 0, -1);
    do_txn(5'd4, 5'd0, 32'h0, 32'h0, 32'h8000_0003, 0, 0, -1);
    do_txn(5'd5, 5'd5, 32'd10, 32'h0040_0000, 32'h0, 1, 1, -1);
    do_txn(5'd2, 5'd0, 32'h5, 32'h6, 32'h0000_0009, 3, 1, 1);
    do_txn(5'd3, 5'd0, 32'h5, 32'h6, 32'h0000_000A, 0, 0, -2);
    do_txn(5'd4, 5'd0, 32'h5, 32'h6, 32'hFFFF_FFE0, 2, 0, -3);
    do_txn(5'd7, 5'd0, 32'h0, 32'h0, 32'h0000_001B, 0, 0, -1);
    do_txn(5'd0, 5'd0, 32'h0, 32'h0, 32'h0000_0004, 2, 1, -1);
    reset_in_resp();
    do_txn(5'd4, 5'd0, 32'h0, 32'h0, 32'h1234_5600, 0, 0, -1);

    for (int t = 0; t < 60; t++) begin
      r = $urandom_range(0, 9);
      sub = (r < 8) ? $urandom_range(1, 5) : ((r == 8) ? 0 : $urandom_range(6, 31));
      d = $urandom_range(0, 4);
      port = $urandom_range(0, 1);
      r = $urandom_range(0, 9);
      fc = (r < 2) ? $urandom_range(0, d) : ((r == 2) ? -2 : ((r == 3) ? -3 : -1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      do_txn(5'(sub), 5'($urandom_range(0, 31)), $urandom, $urandom, $urandom, d, port, fc);
    end

    repeat (5) @(negedge clk);
    chk("queues_empty", issue_q.size() + resp_q.size() + refetch_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
